fp_div_unit: RTL and testbench
==============================

Name: fp_div_unit

Overview:
- Iterative IEEE-754 single-precision divider, result = dividend_i / divisor_i. It is the inverse-operation companion of the FP multiply unit and sits beside it in the FPU execute stage.
- Uses the same float_t operand type and the same FREE/BUSY fu_state_e reporting, so the issue logic handles both units identically.
- Mantissas are divided by a radix-2 restoring iteration, one quotient bit per enabled cycle, followed by normalise and round-to-nearest-even.

Parameters:
- QUOT_BITS, 26: quotient bits produced (24 significand + guard + round). Legal value is 26 only; other values are reserved.

Ports:
- clk_i  input  1  clock.
- rst_n_i  input  1  asynchronous active-low reset.
- clk_en_i  input  1  global clock enable; when low, all state is frozen.
- start_i  input  1  request; sampled only in IDLE with clk_en_i high.
- dividend_i  input  32 (float_t)  numerator; sampled on the accepting edge.
- divisor_i  input  32 (float_t)  denominator; sampled on the accepting edge.
- result_o  output  32 (float_t)  registered quotient; held until the next completion.
- valid_o  output  1  one-cycle pulse when result_o and the flags are updated.
- fu_state_o  output  fu_state_e  FREE in IDLE, BUSY otherwise.
- overflow_o  output  1  registered flag; valid with valid_o.
- underflow_o  output  1  registered flag; valid with valid_o.
- invalid_op_o  output  1  registered flag; valid with valid_o.
- div_by_zero_o  output  1  registered flag; valid with valid_o.

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE. result_o=0, valid_o=0, all flags=0, fu_state_o=FREE. An operation in flight is discarded and produces no valid_o.
- FSM states: IDLE, PREPARE, DIVIDE, NORMALIZE. No transition occurs while clk_en_i=0.
- IDLE: if start_i=1, latch operands and go to PREPARE. start_i is ignored in every other state.
- PREPARE: classify operands. exp==0 is treated as zero (denormals flush to zero); exp==255 with mant==0 is inf; exp==255 with mant!=0 is NaN.
  - Special case: latch the special result and go to NORMALIZE.
  - Otherwise: compute the 10-bit signed exponent e = eA − eB + 127, sign = sA ^ sB, load the remainder with 1.mA, load the divisor with 1.mB, set the iteration counter to QUOT_BITS−1, and go to DIVIDE.
- DIVIDE: each cycle, trial-subtract the divisor from the remainder.
  - If the result is non-negative, shift in quotient bit 1 and keep the difference.
  - Else shift in 0 and keep the remainder.
  - Then shift the remainder left by 1.
  - Go to NORMALIZE when the counter reaches 0 (26 cycles in DIVIDE).
- NORMALIZE: normalise and round, register outputs, pulse valid_o, go to IDLE.
  - If quotient MSB is 0 (mA<mB), shift left by 1 and e−1.
  - Sticky = OR of the final remainder.
  - Round-to-nearest-even on guard/round/sticky. A rounding carry-out increments e and renormalises.
  - e ≥ 255: ±inf (0x7F800000 | sign), overflow_o=1.
  - e ≤ 0: ±0, underflow_o=1 (flush).
- Latency (enabled cycles), counted from the accepting edge to the valid_o cycle: normal operands 29; special cases 3.
- Special results, in priority order:
  - Either operand NaN: 0x7FC00000. invalid_op_o=1 if either operand is a signalling NaN.
  - 0/0 or inf/inf: 0x7FC00000, invalid_op_o=1.
  - finite nonzero / 0: ±inf, div_by_zero_o=1.
  - inf / finite: ±inf, no flag.
  - 0 / nonzero, or finite / inf: ±0, no flag.
- Flags are cleared on every completion that does not set them.
- valid_o and start_i may coincide: the unit is in IDLE during the valid cycle, so a start_i in that cycle is accepted (back-to-back issue).
- clk_en_i low during DIVIDE: the counter, remainder and quotient all hold, and latency stretches by the stalled cycles.

Optional Feature:
- Macro FP_DIV_INEXACT_EN.
- Defined: adds output port inexact_o (1 bit, reset 0), registered with the other flags.
  - inexact_o = guard | round | sticky on normal results.
  - inexact_o = 1 on overflow/underflow results.
  - inexact_o = 0 on special cases.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. 0x40C00000 / 0x40000000 (6.0/2.0) -> valid_o exactly 29 cycles after accept, result_o=0x40400000, all flags 0, fu_state_o BUSY for 28 cycles.
2. 0x3F800000 / 0x40400000 (1.0/3.0) -> result_o=0x3EAAAAAB; inexact_o=1 when FP_DIV_INEXACT_EN is defined.
3. 0x3F800000 / 0x00000000 -> result_o=0x7F800000 and div_by_zero_o=1 after 3 cycles. 0x00000000 / 0x00000000 -> 0x7FC00000, invalid_op_o=1.
4. 0x7F000000 / 0x3E800000 -> result_o=0x7F800000, overflow_o=1. 0x00800000 / 0x40000000 -> 0x00000000, underflow_o=1.
5. 6.0/2.0 with clk_en_i low for 5 cycles mid-DIVIDE -> valid_o after 34 cycles, result_o=0x40400000.
6. rst_n_i low mid-DIVIDE -> immediate IDLE, FREE, result_o=0, no valid_o. Then start_i asserted in the valid_o cycle of a prior operation -> accepted, second result correct.

Source files
------------

// File: rtl/fp_div_unit.sv
// -----------------------------------------------------------------------------
// fp_div_unit -- iterative IEEE-754 single-precision divider (dividend / divisor)
//
// Radix-2 restoring mantissa division, one quotient bit per enabled cycle,
// followed by a single normalise + round-to-nearest-even step. Denormal
// operands are flushed to zero and tiny results are flushed to signed zero.
//
// Optional feature macro: FP_DIV_INEXACT_EN (adds inexact_o when defined).
//
// Ports:
//   clk_i          clock
//   rst_n_i        asynchronous active-low reset
//   clk_en_i       global enable; all state frozen when low
//   start_i        request, accepted only in IDLE
//   dividend_i     numerator (float_t), latched on the accepting edge
//   divisor_i      denominator (float_t), latched on the accepting edge
//   result_o       registered quotient, held until the next completion
//   valid_o        one-cycle pulse when result_o and the flags update
//   fu_state_o     FREE in IDLE, BUSY otherwise
//   overflow_o     result overflowed to +/-inf
//   underflow_o    result flushed to +/-0
//   invalid_op_o   invalid operation (0/0, inf/inf, signalling NaN)
//   div_by_zero_o  finite nonzero divided by zero
//   inexact_o      (FP_DIV_INEXACT_EN only) rounded or overflow/underflow result
// -----------------------------------------------------------------------------
package fpu_pkg;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float_t;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;
endpackage

module fp_div_unit
    import fpu_pkg::*;
#(
    parameter int QUOT_BITS = 26
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      clk_en_i,
    input  logic      start_i,
    input  float_t    dividend_i,
    input  float_t    divisor_i,
    output float_t    result_o,
    output logic      valid_o,
    output fu_state_e fu_state_o,
    output logic      overflow_o,
    output logic      underflow_o,
    output logic      invalid_op_o,
`ifdef FP_DIV_INEXACT_EN
    output logic      div_by_zero_o,
    output logic      inexact_o
`else
    output logic      div_by_zero_o
`endif
);

    localparam logic [4:0]  CNT_INIT = 5'(QUOT_BITS - 1);
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PREPARE   = 2'd1,
        S_DIVIDE    = 2'd2,
        S_NORMALIZE = 2'd3
    } state_e;

    // Operand classification helpers (denormals count as zero)
    function automatic logic is_zero(input float_t f);
        return (f.exp == 8'd0);
    endfunction

    function automatic logic is_inf(input float_t f);
        return (f.exp == 8'hFF) && (f.mant == 23'd0);
    endfunction

    function automatic logic is_nan(input float_t f);
        return (f.exp == 8'hFF) && (f.mant != 23'd0);
    endfunction

    function automatic logic is_snan(input float_t f);
        return is_nan(f) && !f.mant[22];
    endfunction

    state_e             state_q, state_d;
    float_t             opa_q, opb_q;
    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [24:0]        rem_q;
    logic [23:0]        div_q;
    logic [25:0]        quo_q;
    logic [4:0]         cnt_q;
    logic               special_q, spec_inv_q, spec_dbz_q;
    logic [31:0]        spec_res_q;
    logic [31:0]        result_q;
    logic               valid_q, ovf_q, unf_q, inv_q, dbz_q;
`ifdef FP_DIV_INEXACT_EN
    logic               inx_q;
`endif

    logic               sign_s;
    logic               spec_s, spec_inv_s, spec_dbz_s;
    logic [31:0]        spec_res_s;
    logic               ge_s;
    logic [23:0]        diff_s;
    logic [24:0]        norm_s;
    logic signed [9:0]  exp_n_s, exp_f_s;
    logic               guard_s, rnd_s, sticky_s, rup_s;
    logic [23:0]        sum_s;
    logic [22:0]        mant_f_s;
    logic [31:0]        norm_res_s;
    logic               ovf_s, unf_s, inx_s;

    assign sign_s = opa_q.sign ^ opb_q.sign;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else if (clk_en_i) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_PREPARE;
                else         state_d = S_IDLE;
            end
            S_PREPARE: begin
                if (spec_s) state_d = S_NORMALIZE;
                else        state_d = S_DIVIDE;
            end
            S_DIVIDE: begin
                if (cnt_q == 5'd0) state_d = S_NORMALIZE;
                else               state_d = S_DIVIDE;
            end
            S_NORMALIZE: state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Unit status output decoded from the state register
    always_comb begin
        if (state_q == S_IDLE) fu_state_o = FREE;
        else                   fu_state_o = BUSY;
    end

    // Special-operand resolution in priority order
    always_comb begin
        spec_s     = 1'b1;
        spec_inv_s = 1'b0;
        spec_dbz_s = 1'b0;
        spec_res_s = 32'd0;
        if (is_nan(opa_q) || is_nan(opb_q)) begin
            spec_res_s = QNAN;
            spec_inv_s = is_snan(opa_q) || is_snan(opb_q);
        end else if ((is_zero(opa_q) && is_zero(opb_q)) || (is_inf(opa_q) && is_inf(opb_q))) begin
            spec_res_s = QNAN;
            spec_inv_s = 1'b1;
        end else if (is_zero(opb_q)) begin
            // inf/0 gives inf without a flag; only finite/0 is a divide-by-zero
            spec_res_s = {sign_s, 8'hFF, 23'd0};
            spec_dbz_s = !is_inf(opa_q);
        end else if (is_inf(opa_q)) begin
            spec_res_s = {sign_s, 8'hFF, 23'd0};
        end else if (is_zero(opa_q) || is_inf(opb_q)) begin
            spec_res_s = {sign_s, 31'd0};
        end else begin
            spec_s = 1'b0;
        end
    end

    // Restoring trial subtraction; when rem >= div the difference fits in 24 bits
    always_comb begin
        ge_s   = (rem_q >= {1'b0, div_q});
        diff_s = rem_q[23:0] - div_q;
    end

    // Normalise, round to nearest even, and range-check the exponent
    always_comb begin
        if (quo_q[25]) begin
            norm_s  = quo_q[24:0];
            exp_n_s = exp_q;
        end else begin
            // Quotient below 1.0: the missing round bit is covered by sticky
            norm_s  = {quo_q[23:0], 1'b0};
            exp_n_s = exp_q - 10'sd1;
        end
        guard_s  = norm_s[1];
        rnd_s    = norm_s[0];
        sticky_s = |rem_q;
        rup_s    = guard_s & (rnd_s | sticky_s | norm_s[2]);
        sum_s    = {1'b0, norm_s[24:2]} + {23'd0, rup_s};
        if (sum_s[23]) begin
            mant_f_s = 23'd0;
            exp_f_s  = exp_n_s + 10'sd1;
        end else begin
            mant_f_s = sum_s[22:0];
            exp_f_s  = exp_n_s;
        end
        ovf_s = 1'b0;
        unf_s = 1'b0;
        inx_s = guard_s | rnd_s | sticky_s;
        if (exp_f_s >= 10'sd255) begin
            norm_res_s = {sign_q, 8'hFF, 23'd0};
            ovf_s      = 1'b1;
            inx_s      = 1'b1;
        end else if (exp_f_s <= 10'sd0) begin
            norm_res_s = {sign_q, 31'd0};
            unf_s      = 1'b1;
            inx_s      = 1'b1;
        end else begin
            norm_res_s = {sign_q, exp_f_s[7:0], mant_f_s};
        end
    end

    // Datapath and output registers, advanced only on enabled cycles
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            opa_q      <= '0;
            opb_q      <= '0;
            sign_q     <= 1'b0;
            exp_q      <= 10'sd0;
            rem_q      <= 25'd0;
            div_q      <= 24'd0;
            quo_q      <= 26'd0;
            cnt_q      <= 5'd0;
            special_q  <= 1'b0;
            spec_inv_q <= 1'b0;
            spec_dbz_q <= 1'b0;
            spec_res_q <= 32'd0;
            result_q   <= 32'd0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            inv_q      <= 1'b0;
            dbz_q      <= 1'b0;
`ifdef FP_DIV_INEXACT_EN
            inx_q      <= 1'b0;
`endif
        end else if (clk_en_i) begin
            valid_q <= (state_q == S_NORMALIZE);
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        opa_q <= dividend_i;
                        opb_q <= divisor_i;
                    end
                end
                S_PREPARE: begin
                    special_q  <= spec_s;
                    spec_inv_q <= spec_inv_s;
                    spec_dbz_q <= spec_dbz_s;
                    spec_res_q <= spec_res_s;
                    sign_q     <= sign_s;
                    exp_q      <= $signed({2'b00, opa_q.exp}) - $signed({2'b00, opb_q.exp}) + 10'sd127;
                    rem_q      <= {2'b01, opa_q.mant};
                    div_q      <= {1'b1, opb_q.mant};
                    cnt_q      <= CNT_INIT;
                end
                S_DIVIDE: begin
                    quo_q <= {quo_q[24:0], ge_s};
                    if (ge_s) rem_q <= {diff_s, 1'b0};
                    else      rem_q <= {rem_q[23:0], 1'b0};
                    cnt_q <= cnt_q - 5'd1;
                end
                S_NORMALIZE: begin
                    if (special_q) begin
                        result_q <= spec_res_q;
                        ovf_q    <= 1'b0;
                        unf_q    <= 1'b0;
                        inv_q    <= spec_inv_q;
                        dbz_q    <= spec_dbz_q;
`ifdef FP_DIV_INEXACT_EN
                        inx_q    <= 1'b0;
`endif
                    end else begin
                        result_q <= norm_res_s;
                        ovf_q    <= ovf_s;
                        unf_q    <= unf_s;
                        inv_q    <= 1'b0;
                        dbz_q    <= 1'b0;
`ifdef FP_DIV_INEXACT_EN
                        inx_q    <= inx_s;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o      = result_q;
    assign valid_o       = valid_q;
    assign overflow_o    = ovf_q;
    assign underflow_o   = unf_q;
    assign invalid_op_o  = inv_q;
    assign div_by_zero_o = dbz_q;
`ifdef FP_DIV_INEXACT_EN
    assign inexact_o     = inx_q;
`endif

endmodule

// File: tb/tb_fp_div_unit.sv
// -----------------------------------------------------------------------------
// tb_fp_div_unit -- scoreboard bench for fp_div_unit.
// Stimulus pushes expected responses (from an integer-arithmetic reference
// model) into a queue; a negedge monitor pops and compares on every valid_o.
// -----------------------------------------------------------------------------
module tb_fp_div_unit;
    import fpu_pkg::*;

    typedef struct {
        logic [31:0] res;
        bit          ovf, unf, inv, dbz, inx;
        int          lat;
        int          exp_wall;
        int          exp_busy;
        int          acc_en;
        int          acc_wall;
    } sb_t;

    logic      clk = 1'b0;
    logic      rst_n, clk_en, start;
    float_t    a_i, b_i, res_o;
    logic      valid_o, ovf_o, unf_o, inv_o, dbz_o;
    fu_state_e st_o;
`ifdef FP_DIV_INEXACT_EN
    logic      inx_o;
`endif

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  en_cnt   = 0;
    int  wall     = 0;
    bit  last_en  = 1'b0;
    int  busy_run = 0;
    int  stall_pct = 0;
    bit  hold_lo   = 1'b0;
    bit  last_issue_in_valid = 1'b0;

    fp_div_unit dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .clk_en_i      (clk_en),
        .start_i       (start),
        .dividend_i    (a_i),
        .divisor_i     (b_i),
        .result_o      (res_o),
        .valid_o       (valid_o),
        .fu_state_o    (st_o),
        .overflow_o    (ovf_o),
        .underflow_o   (unf_o),
        .invalid_op_o  (inv_o),
`ifdef FP_DIV_INEXACT_EN
        .div_by_zero_o (dbz_o),
        .inexact_o     (inx_o)
`else
        .div_by_zero_o (dbz_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: exact integer quotient, then IEEE rounding rules
    function automatic sb_t model(input logic [31:0] a, input logic [31:0] b);
        sb_t m;
        logic sa, sb, s;
        logic [7:0] ea, eb;
        logic [22:0] ma, mb;
        bit a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
        longint unsigned num, den, q, r, keep, low, half;
        int e, sh;
        bit up;
        sa = a[31]; ea = a[30:23]; ma = a[22:0];
        sb = b[31]; eb = b[30:23]; mb = b[22:0];
        s  = sa ^ sb;
        a_zero = (ea == 8'd0);  b_zero = (eb == 8'd0);
        a_inf  = (ea == 8'hFF) && (ma == 23'd0);
        b_inf  = (eb == 8'hFF) && (mb == 23'd0);
        a_nan  = (ea == 8'hFF) && (ma != 23'd0);
        b_nan  = (eb == 8'hFF) && (mb != 23'd0);
        a_snan = a_nan && !ma[22];
        b_snan = b_nan && !mb[22];
        m.res = 32'd0; m.ovf = 0; m.unf = 0; m.inv = 0; m.dbz = 0; m.inx = 0;
        m.lat = 3; m.exp_wall = -1; m.exp_busy = -1; m.acc_en = 0; m.acc_wall = 0;
        if (a_nan || b_nan) begin
            m.res = 32'h7FC00000; m.inv = a_snan || b_snan;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            m.res = 32'h7FC00000; m.inv = 1;
        end else if (b_zero) begin
            m.res = {s, 8'hFF, 23'd0}; m.dbz = !a_inf;
        end else if (a_inf) begin
            m.res = {s, 8'hFF, 23'd0};
        end else if (a_zero || b_inf) begin
            m.res = {s, 31'd0};
        end else begin
            m.lat = 29;
            num = {40'd0, 1'b1, ma} << 26;
            den = {40'd0, 1'b1, mb};
            q = num / den;
            r = num % den;
            e = int'(ea) - int'(eb) + 127;
            if (q >= (64'd1 << 26)) sh = 3;
            else begin sh = 2; e = e - 1; end
            keep = q >> sh;
            low  = q & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            up   = (low > half) || ((low == half) && ((r != 0) || keep[0]));
            m.inx = (low != 0) || (r != 0);
            keep = keep + (up ? 64'd1 : 64'd0);
            if (keep == (64'd1 << 24)) begin keep = 64'd1 << 23; e = e + 1; end
            if (e >= 255) begin
                m.res = {s, 8'hFF, 23'd0}; m.ovf = 1; m.inx = 1;
            end else if (e <= 0) begin
                m.res = {s, 31'd0}; m.unf = 1; m.inx = 1;
            end else begin
                m.res = {s, 8'(e), keep[22:0]};
            end
        end
        return m;
    endfunction

    function automatic logic [31:0] gen();
        int k;
        logic s;
        logic [7:0] e;
        logic [22:0] m;
        k = int'($urandom_range(0, 99));
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom);
        if (k < 60)      e = 8'($urandom_range(1, 254));
        else if (k < 75) e = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 20)) : 8'($urandom_range(235, 254));
        else if (k < 83) begin e = 8'd0; if ($urandom_range(0, 1) != 0) m = 23'd0; end
        else if (k < 90) begin e = 8'hFF; m = 23'd0; end
        else if (k < 95) begin e = 8'hFF; m[22] = 1'b0; if (m == 23'd0) m = 23'd1; end
        else begin e = 8'hFF; m[22] = 1'b1; end
        return {s, e, m};
    endfunction

    // Edge bookkeeping: enabled-edge and wall-clock counters
    always @(posedge clk) begin
        wall    <= wall + 1;
        if (clk_en && rst_n) en_cnt <= en_cnt + 1;
        last_en <= clk_en && rst_n;
    end

    // Monitor: pop and compare on every fresh valid_o pulse
    always @(negedge clk) begin
        sb_t e;
        if (rst_n) begin
            if (st_o == BUSY) begin
                busy_run++;
            end else begin
                if (valid_o && last_en) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("result",       res_o, e.res);
                        chk("overflow",     {31'd0, ovf_o}, {31'd0, e.ovf});
                        chk("underflow",    {31'd0, unf_o}, {31'd0, e.unf});
                        chk("invalid_op",   {31'd0, inv_o}, {31'd0, e.inv});
                        chk("div_by_zero",  {31'd0, dbz_o}, {31'd0, e.dbz});
`ifdef FP_DIV_INEXACT_EN
                        chk("inexact",      {31'd0, inx_o}, {31'd0, e.inx});
`endif
                        chk("latency_enabled", en_cnt - e.acc_en + 1, e.lat);
                        if (e.exp_wall >= 0) chk("latency_wall", wall - e.acc_wall + 1, e.exp_wall);
                        if (e.exp_busy >= 0) chk("busy_cycles", busy_run, e.exp_busy);
                    end
                end
                busy_run = 0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        clk_en = hold_lo ? 1'b0 : (int'($urandom_range(0, 99)) >= stall_pct);
        if (rst_n && st_o == BUSY && $urandom_range(0, 3) == 0) begin
            start = 1'b1;
            a_i   = $urandom;
            b_i   = $urandom;
        end else begin
            start = 1'b0;
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit use_dir,
                         input logic [31:0] dres, input logic [3:0] dflags,
                         input int ewall, input int ebusy);
        sb_t e;
        bit done;
        done = 1'b0;
        e = model(a, b);
        if (use_dir) begin
            e.res = dres;
            {e.ovf, e.unf, e.inv, e.dbz} = dflags;
        end
        e.exp_wall = ewall;
        e.exp_busy = ebusy;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            clk_en = hold_lo ? 1'b0 : (int'($urandom_range(0, 99)) >= stall_pct);
            if (st_o == FREE && clk_en) begin
                start = 1'b1;
                a_i   = a;
                b_i   = b;
                e.acc_en   = en_cnt + 1;
                e.acc_wall = wall + 1;
                last_issue_in_valid = valid_o;
                sb_q.push_back(e);
                done = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        if (!done) chk("issue_timeout", 32'd1, 32'd0);
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && sb_q.size() != 0; i++) step();
        if (sb_q.size() != 0) begin
            chk("drain_timeout", sb_q.size(), 32'd0);
            sb_q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        rst_n = 1'b0; clk_en = 1'b0; start = 1'b0; a_i = '0; b_i = '0;
        #12;
        chk("reset_result", res_o, 32'd0);
        chk("reset_valid",  {31'd0, valid_o}, 32'd0);
        chk("reset_flags",  {28'd0, ovf_o, unf_o, inv_o, dbz_o}, 32'd0);
        chk("reset_state",  {31'd0, st_o}, {31'd0, FREE});
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: normal, rounding, specials, overflow/underflow
        issue(32'h40C00000, 32'h40000000, 1, 32'h40400000, 4'b0000, 29, 28); drain();
        issue(32'h3F800000, 32'h40400000, 1, 32'h3EAAAAAB, 4'b0000, -1, -1); drain();
        issue(32'h3F800000, 32'h00000000, 1, 32'h7F800000, 4'b0001, 3, 2);   drain();
        issue(32'h00000000, 32'h00000000, 1, 32'h7FC00000, 4'b0010, -1, -1); drain();
        issue(32'h7F000000, 32'h3E800000, 1, 32'h7F800000, 4'b1000, -1, -1); drain();
        issue(32'h00800000, 32'h40000000, 1, 32'h00000000, 4'b0100, -1, -1); drain();

        // Stall of five cycles in the middle of the divide phase
        issue(32'h40C00000, 32'h40000000, 1, 32'h40400000, 4'b0000, 34, -1);
        for (int i = 0; i < 8; i++) step();
        hold_lo = 1'b1;
        for (int i = 0; i < 5; i++) step();
        hold_lo = 1'b0;
        drain();

        // Asynchronous reset in flight: immediate idle, cleared outputs, no valid
        issue(32'h40C00000, 32'h40000000, 0, 32'd0, 4'd0, -1, -1);
        for (int i = 0; i < 10; i++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_state",  {31'd0, st_o}, {31'd0, FREE});
        chk("midrst_result", res_o, 32'd0);
        chk("midrst_valid",  {31'd0, valid_o}, 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) step();

        // Back-to-back issue in the valid cycle of the previous operation
        issue(32'h40C00000, 32'h40000000, 1, 32'h40400000, 4'b0000, 29, -1);
        issue(32'h3F800000, 32'h40400000, 1, 32'h3EAAAAAB, 4'b0000, 29, -1);
        chk("b2b_start_in_valid_cycle", {31'd0, last_issue_in_valid}, 32'd1);
        drain();

        // Randomized operands with random clock-enable stalls
        stall_pct = 20;
        for (int n = 0; n < 150; n++) begin
            ra = gen();
            rb = gen();
            if ($urandom_range(0, 9) == 0) rb[22:0] = ra[22:0];
            issue(ra, rb, 0, 32'd0, 4'd0, -1, -1);
        end
        drain();
        stall_pct = 0;
        for (int i = 0; i < 5; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
